// File: rtl/uart_rx.sv
// 8N1 UART receiver.
// The serial line is brought into the clock domain through a two-flop
// synchronizer. A single FSM then frames each byte: it confirms the start bit
// at its middle, samples eight data bits one bit-period apart (LSB first) and
// checks the stop bit. A good frame updates rx_data with a one-cycle rx_valid
// strobe. A low stop bit gives a one-cycle frame_err strobe, and the receiver
// then waits for the line to return high.

module uart_rx #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    // Clocks per bit period; the receiver needs at least 4 to find a bit centre.
    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int CNT_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

    // Half a bit into the start bit, and the last clock of a full bit period.
    localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t             state;
    logic               rx_m;
    logic               rx_s;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         bit_idx;
    logic [7:0]         shift;

    // Two-flop synchronizer for the asynchronous line; resets to idle-high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // Framing FSM with registered data, strobes and busy flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;

            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state <= ST_START;
                        busy  <= 1'b1;
                    end
                end

                ST_START: begin
                    if (cnt == MID_CNT) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            // Start bit confirmed at its centre; data bits
                            // are now sampled one full period apart.
                            state   <= ST_DATA;
                            bit_idx <= '0;
                        end else begin
                            // Line went back high: a glitch, not a frame.
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (cnt == LAST_CNT) begin
                        cnt   <= '0;
                        shift <= {rx_s, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_STOP: begin
                    if (cnt == LAST_CNT) begin
                        cnt <= '0;
                        if (rx_s) begin
                            // Returning to idle mid stop bit leaves half a
                            // bit of margin for a back-to-back start bit.
                            rx_data  <= shift;
                            rx_valid <= 1'b1;
                            state    <= ST_IDLE;
                            busy     <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= ST_BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_BREAK: begin
                    // Hold off until the line is released so a long low
                    // level is not mistaken for a stream of start bits.
                    cnt <= '0;
                    if (rx_s) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
